// File: rtl/jtag_mem_burst_engine_if.sv
// Command, write/read beat and memory-port bundle for jtag_mem_burst_engine.
// slave is the engine's view; master is the JTAG command side plus the memory ports.
interface jtag_mem_burst_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2,
  parameter int LEN_WIDTH  = 8
);
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic                            cmd_write;
  logic [ADDR_WIDTH-1:0]           cmd_addr;
  logic [LEN_WIDTH-1:0]            cmd_len;
  logic                            abort;
  logic                            wr_data_valid;
  logic                            wr_data_ready;
  logic [DATA_WIDTH-1:0]           wr_data;
  logic                            rd_data_valid;
  logic                            rd_data_ready;
  logic [DATA_WIDTH-1:0]           rd_data;
  logic [NUM_PORTS-1:0]            mem_enable;
  logic                            mem_write;
  logic [ADDR_WIDTH-1:0]           mem_address;
  logic [DATA_WIDTH-1:0]           mem_write_data;
  logic [NUM_PORTS*DATA_WIDTH-1:0] mem_read_data;
  logic [NUM_PORTS-1:0]            mem_ready;
  logic [NUM_PORTS-1:0]            mem_error;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, abort,
    output cmd_ready,
    input  wr_data_valid, wr_data,
    output wr_data_ready,
    output rd_data_valid, rd_data,
    input  rd_data_ready,
    output mem_enable, mem_write, mem_address, mem_write_data,
    input  mem_read_data, mem_ready, mem_error
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, abort,
    input  cmd_ready,
    output wr_data_valid, wr_data,
    input  wr_data_ready,
    input  rd_data_valid, rd_data,
    output rd_data_ready,
    input  mem_enable, mem_write, mem_address, mem_write_data,
    output mem_read_data, mem_ready, mem_error
  );
endinterface

// File: rtl/jtag_mem_burst_engine.sv
// Burst engine: JTAG burst commands -> auto-incrementing single-beat requests on NUM_PORTS memory ports.
// Optional running beat checksum enabled by defining JTAG_MEM_BURST_CHECKSUM_EN.
module jtag_mem_burst_engine #(
  parameter int         ADDR_WIDTH     = 32,
  parameter int         DATA_WIDTH     = 32,
  parameter int         NUM_PORTS      = 2,
  parameter int         PORT_SHIFT     = 12,
  parameter int         LEN_WIDTH      = 8,
  parameter int         TIMEOUT_CYCLES = 256,
  parameter logic [7:0] WR_MIN_LEVEL   = 8'h02
) (
  input  logic                  clk,
  input  logic                  reset,
  jtag_mem_burst_engine_if.slave bus,
  input  logic                  debug_mode,
  input  logic [7:0]            access_level,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            error_code,
  output logic [LEN_WIDTH:0]    beat_count,
  output logic [31:0]           checksum
);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH:0]   ADDR_STEP  = (ADDR_WIDTH+1)'(DATA_WIDTH / 8);
  localparam logic [LEN_WIDTH:0]    BEAT_ONE   = (LEN_WIDTH+1)'(1);
  localparam logic [TMR_W-1:0]      TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0]      TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] PORT_LIMIT = ADDR_WIDTH'(NUM_PORTS);

  localparam logic [7:0] ERR_ACCESS  = 8'h01;
  localparam logic [7:0] ERR_MEM     = 8'h02;
  localparam logic [7:0] ERR_TIMEOUT = 8'h03;
  localparam logic [7:0] ERR_DECODE  = 8'h04;
  localparam logic [7:0] ERR_WRAP    = 8'h05;
  localparam logic [7:0] ERR_ABORT   = 8'h06;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

  state_t                 state_reg, state_next;
  logic [7:0]             fail_code;
  logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]   len_reg, len_next;
  logic                   write_reg, write_next;
  logic [PORT_W-1:0]      port_reg, port_next;
  logic [TMR_W-1:0]       timer_reg, timer_next;
  logic [NUM_PORTS-1:0]   mem_enable_reg, mem_enable_next;
  logic                   mem_write_reg, mem_write_next;
  logic [ADDR_WIDTH-1:0]  mem_address_reg, mem_address_next;
  logic [DATA_WIDTH-1:0]  mem_write_data_reg, mem_write_data_next;
  logic [DATA_WIDTH-1:0]  rd_data_reg, rd_data_next;
  logic                   rd_valid_reg, rd_valid_next;
  logic [LEN_WIDTH:0]     beat_count_reg, beat_count_next;
  logic                   error_reg, error_next;
  logic [7:0]             error_code_reg, error_code_next;
  logic                   done_reg, done_next;

  logic [DATA_WIDTH-1:0]  rd_slice [NUM_PORTS];
  logic [ADDR_WIDTH-1:0]  port_full;
  logic [PORT_W-1:0]      port_idx;
  logic                   decode_ok, issue_go, beat_ready, beat_err, beat_ok;
  logic                   last_beat, timer_hit, addr_carry;
  logic [ADDR_WIDTH:0]    addr_sum;
  logic [LEN_WIDTH:0]     beat_inc;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slice
    assign rd_slice[gi] = bus.mem_read_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign port_full  = addr_reg >> PORT_SHIFT;
  assign decode_ok  = port_full < PORT_LIMIT;
  assign port_idx   = port_full[PORT_W-1:0];
  // A read beat may only go out once the previous one has been taken.
  assign issue_go   = (state_reg == ISSUE) && decode_ok &&
                      (write_reg ? bus.wr_data_valid : !rd_valid_reg);
  assign beat_ready = bus.mem_ready[port_reg];
  assign beat_err   = bus.mem_error[port_reg];
  assign beat_ok    = (state_reg == WAIT) && !bus.abort && beat_ready && !beat_err;
  assign beat_inc   = beat_count_reg + BEAT_ONE;
  assign last_beat  = beat_inc == ({1'b0, len_reg} + BEAT_ONE);
  assign timer_hit  = timer_reg == TMR_LAST;
  assign addr_sum   = {1'b0, addr_reg} + ADDR_STEP;
  assign addr_carry = addr_sum[ADDR_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // DONE and ERR last a single cycle, so abort is only honoured while a beat is pending.
  always_comb begin
    state_next = state_reg;
    fail_code  = 8'h00;
    case (state_reg)
      IDLE: if (bus.cmd_valid) begin
        if (bus.cmd_write && !debug_mode && (access_level < WR_MIN_LEVEL)) begin
          state_next = ERR;
          fail_code  = ERR_ACCESS;
        end else begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.abort) begin
          state_next = ERR;
          fail_code  = ERR_ABORT;
        end else if (!decode_ok) begin
          state_next = ERR;
          fail_code  = ERR_DECODE;
        end else if (issue_go) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.abort) begin
          state_next = ERR;
          fail_code  = ERR_ABORT;
        end else if (beat_ready) begin
          if (beat_err) begin
            state_next = ERR;
            fail_code  = ERR_MEM;
          end else if (last_beat) begin
            state_next = DONE;
          end else if (addr_carry) begin
            state_next = ERR;
            fail_code  = ERR_WRAP;
          end else begin
            state_next = ISSUE;
          end
        end else if (timer_hit) begin
          state_next = ERR;
          fail_code  = ERR_TIMEOUT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    addr_next           = addr_reg;
    len_next            = len_reg;
    write_next          = write_reg;
    port_next           = port_reg;
    timer_next          = timer_reg;
    mem_enable_next     = mem_enable_reg;
    mem_write_next      = mem_write_reg;
    mem_address_next    = mem_address_reg;
    mem_write_data_next = mem_write_data_reg;
    rd_data_next        = rd_data_reg;
    rd_valid_next       = rd_valid_reg && !bus.rd_data_ready;
    beat_count_next     = beat_count_reg;
    error_next          = error_reg;
    error_code_next     = error_code_reg;
    done_next           = (state_next == DONE);
    case (state_reg)
      IDLE: if (bus.cmd_valid) begin
        addr_next       = bus.cmd_addr;
        len_next        = bus.cmd_len;
        write_next      = bus.cmd_write;
        beat_count_next = '0;
        error_next      = 1'b0;
        error_code_next = 8'h00;
      end
      ISSUE: if (!bus.abort && issue_go) begin
        mem_enable_next     = NUM_PORTS'(1) << port_idx;
        mem_write_next      = write_reg;
        mem_address_next    = addr_reg;
        mem_write_data_next = write_reg ? bus.wr_data : '0;
        port_next           = port_idx;
        timer_next          = '0;
      end
      WAIT: begin
        if (bus.abort || beat_ready || timer_hit) mem_enable_next = '0;
        else                                      timer_next      = timer_reg + TMR_ONE;
        if (beat_ok) begin
          beat_count_next = beat_inc;
          addr_next       = addr_sum[ADDR_WIDTH-1:0];
          if (!mem_write_reg) begin
            rd_data_next  = rd_slice[port_reg];
            rd_valid_next = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (fail_code != 8'h00) begin
      error_next      = 1'b1;
      error_code_next = fail_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg           <= '0;
      len_reg            <= '0;
      write_reg          <= 1'b0;
      port_reg           <= '0;
      timer_reg          <= '0;
      mem_enable_reg     <= '0;
      mem_write_reg      <= 1'b0;
      mem_address_reg    <= '0;
      mem_write_data_reg <= '0;
      rd_data_reg        <= '0;
      rd_valid_reg       <= 1'b0;
      beat_count_reg     <= '0;
      error_reg          <= 1'b0;
      error_code_reg     <= 8'h00;
      done_reg           <= 1'b0;
    end else begin
      addr_reg           <= addr_next;
      len_reg            <= len_next;
      write_reg          <= write_next;
      port_reg           <= port_next;
      timer_reg          <= timer_next;
      mem_enable_reg     <= mem_enable_next;
      mem_write_reg      <= mem_write_next;
      mem_address_reg    <= mem_address_next;
      mem_write_data_reg <= mem_write_data_next;
      rd_data_reg        <= rd_data_next;
      rd_valid_reg       <= rd_valid_next;
      beat_count_reg     <= beat_count_next;
      error_reg          <= error_next;
      error_code_reg     <= error_code_next;
      done_reg           <= done_next;
    end
  end

`ifdef JTAG_MEM_BURST_CHECKSUM_EN
  logic [31:0]           checksum_reg;
  logic [DATA_WIDTH-1:0] beat_data;

  assign beat_data = mem_write_reg ? mem_write_data_reg : rd_slice[port_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     checksum_reg <= '0;
    else if (state_reg == IDLE && bus.cmd_valid)   checksum_reg <= '0;
    else if (beat_ok)                              checksum_reg <= checksum_reg + 32'(beat_data);
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

  assign bus.cmd_ready      = (state_reg == IDLE);
  assign bus.wr_data_ready  = (state_reg == ISSUE) && write_reg && decode_ok;
  assign bus.rd_data_valid  = rd_valid_reg;
  assign bus.rd_data        = rd_data_reg;
  assign bus.mem_enable     = mem_enable_reg;
  assign bus.mem_write      = mem_write_reg;
  assign bus.mem_address    = mem_address_reg;
  assign bus.mem_write_data = mem_write_data_reg;
  assign busy               = (state_reg != IDLE);
  assign done               = done_reg;
  assign error              = error_reg;
  assign error_code         = error_code_reg;
  assign beat_count         = beat_count_reg;
endmodule

// File: tb/tb_jtag_mem_burst_engine.sv
`timescale 1ns/1ps
module tb_jtag_mem_burst_engine;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NP = 2;
    localparam int LW = 8;
`ifdef JTAG_MEM_BURST_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          debug_mode = 1'b0;
    logic [7:0]    access_level = 8'h00;
    logic          busy, done, error;
    logic [7:0]    error_code;
    logic [LW:0]   beat_count;
    logic [31:0]   checksum;
    int            n_checks = 0;
    int            n_fail = 0;

    jtag_mem_burst_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP), .LEN_WIDTH(LW)) bus ();

    jtag_mem_burst_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .bus(bus), .debug_mode(debug_mode), .access_level(access_level),
        .busy(busy), .done(done), .error(error), .error_code(error_code),
        .beat_count(beat_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if ((bus.mem_enable & (bus.mem_enable - NP'(1))) !== '0) begin
                n_fail++;
                $error("FAIL onehot: observed=%0h expected=onehot", bus.mem_enable);
            end
            if (bus.cmd_ready !== !busy) begin
                n_fail++;
                $error("FAIL cmd_ready_busy: observed=%0h expected=%0h", bus.cmd_ready, !busy);
            end
        end
    end

    task automatic send_cmd(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        check("cmd_ready_idle", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        $display("cmd write=%0d addr=%08h len=%0d", wr, addr, len);
    endtask

    task automatic wait_enable();
        int waited = 0;
        while (bus.mem_enable == '0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("enable_seen", (bus.mem_enable != '0), 1'b1);
    endtask

    task automatic read_beat(input logic [AW-1:0] addr, input int port,
                             input logic [DW-1:0] data, input bit err);
        logic [NP-1:0] onehot;
        onehot = NP'(1) << port;
        wait_enable();
        check("rd_enable", bus.mem_enable, onehot);
        check("rd_mem_write", bus.mem_write, 1'b0);
        check("rd_address", bus.mem_address, addr);
        bus.mem_ready[port] = 1'b1;
        bus.mem_error[port] = err;
        bus.mem_read_data[port*DW +: DW] = data;
        @(negedge clk);
        bus.mem_ready = '0;
        bus.mem_error = '0;
        check("rd_enable_drop", bus.mem_enable, 2'b00);
        if (!err) begin
            check("rd_data", bus.rd_data, data);
            check("rd_valid", bus.rd_data_valid, 1'b1);
        end
        $display("read beat addr=%08h port=%0d data=%08h err=%0d", addr, port, data, err);
    endtask

    task automatic write_beat(input logic [AW-1:0] addr, input int port, input logic [DW-1:0] data);
        logic [NP-1:0] onehot;
        onehot = NP'(1) << port;
        bus.wr_data_valid = 1'b1;
        bus.wr_data       = data;
        for (int i = 0; i < 20 && !bus.wr_data_ready; i++) @(negedge clk);
        check("wr_ready", bus.wr_data_ready, 1'b1);
        @(negedge clk);
        bus.wr_data_valid = 1'b0;
        check("wr_enable", bus.mem_enable, onehot);
        check("wr_mem_write", bus.mem_write, 1'b1);
        check("wr_address", bus.mem_address, addr);
        check("wr_data", bus.mem_write_data, data);
        bus.mem_ready[port] = 1'b1;
        @(negedge clk);
        bus.mem_ready = '0;
        check("wr_enable_drop", bus.mem_enable, 2'b00);
        $display("write beat addr=%08h port=%0d data=%08h", addr, port, data);
    endtask

    task automatic consume_rd();
        bus.rd_data_ready = 1'b1;
        @(negedge clk);
        bus.rd_data_ready = 1'b0;
        check("rd_valid_clear", bus.rd_data_valid, 1'b0);
    endtask

    initial begin
        int cnt;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.abort = 1'b0; bus.wr_data_valid = 1'b0; bus.wr_data = '0; bus.rd_data_ready = 1'b0;
        bus.mem_read_data = '0; bus.mem_ready = '0; bus.mem_error = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_code", error_code, 8'h00);
        check("rst_beats", beat_count, 9'd0);
        check("rst_checksum", checksum, 32'h0);
        check("rst_enable", bus.mem_enable, 2'b00);
        check("rst_rd_valid", bus.rd_data_valid, 1'b0);

        send_cmd(1'b0, 32'h0000_0010, 8'd0);
        check("t1_busy", busy, 1'b1);
        check("t1_no_enable_yet", bus.mem_enable, 2'b00);
        @(negedge clk);
        check("t1_enable_two_edges", bus.mem_enable, 2'b01);
        read_beat(32'h0000_0010, 0, 32'hDEADBEEF, 1'b0);
        check("t1_done", done, 1'b1);
        check("t1_beats", beat_count, 9'd1);
        check("t1_checksum", checksum, (CSUM_EN ? 32'hDEADBEEF : 32'h0));
        @(negedge clk);
        check("t1_done_pulse", done, 1'b0);
        check("t1_idle", busy, 1'b0);
        consume_rd();

        debug_mode = 1'b1;
        send_cmd(1'b1, 32'h0000_0FF8, 8'd3);
        write_beat(32'h0000_0FF8, 0, 32'd1);
        write_beat(32'h0000_0FFC, 0, 32'd2);
        write_beat(32'h0000_1000, 1, 32'd3);
        write_beat(32'h0000_1004, 1, 32'd4);
        check("t2_done", done, 1'b1);
        check("t2_beats", beat_count, 9'd4);
        check("t2_checksum", checksum, (CSUM_EN ? 32'd10 : 32'h0));
        check("t2_error", error, 1'b0);
        @(negedge clk);
        check("t2_idle", busy, 1'b0);
        debug_mode = 1'b0;

        send_cmd(1'b0, 32'h0000_0100, 8'd7);
        read_beat(32'h0000_0100, 0, 32'hA5A5_0001, 1'b0);
        consume_rd();
        read_beat(32'h0000_0104, 0, 32'hA5A5_0002, 1'b0);
        consume_rd();
        read_beat(32'h0000_0108, 0, 32'hA5A5_0003, 1'b1);
        check("t3_error", error, 1'b1);
        check("t3_code", error_code, 8'h02);
        check("t3_beats", beat_count, 9'd2);
        check("t3_no_done", done, 1'b0);
        check("t3_rd_valid", bus.rd_data_valid, 1'b0);
        @(negedge clk);
        check("t3_idle", busy, 1'b0);
        check("t3_sticky", error, 1'b1);

        access_level = 8'h01;
        bus.wr_data_valid = 1'b1;
        bus.wr_data = 32'h5555_AAAA;
        send_cmd(1'b1, 32'h0000_0200, 8'd0);
        check("t4_access_error", error, 1'b1);
        check("t4_access_code", error_code, 8'h01);
        check("t4_access_no_enable", bus.mem_enable, 2'b00);
        check("t4_access_no_wr_ready", bus.wr_data_ready, 1'b0);
        @(negedge clk);
        check("t4_access_idle", busy, 1'b0);
        debug_mode = 1'b1;
        send_cmd(1'b1, 32'h0000_3000, 8'd0);
        check("t4_error_cleared", error, 1'b0);
        check("t4_decode_no_wr_ready", bus.wr_data_ready, 1'b0);
        @(negedge clk);
        check("t4_decode_code", error_code, 8'h04);
        check("t4_decode_error", error, 1'b1);
        check("t4_decode_no_enable", bus.mem_enable, 2'b00);
        bus.wr_data_valid = 1'b0;
        debug_mode = 1'b0;
        access_level = 8'h02;
        @(negedge clk);

        send_cmd(1'b0, 32'h0000_0020, 8'd0);
        wait_enable();
        cnt = 0;
        while (bus.mem_enable != '0 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        check("t5_enable_cycles", cnt, 256);
        check("t5_code", error_code, 8'h03);
        check("t5_error", error, 1'b1);
        @(negedge clk);
        check("t5_idle", busy, 1'b0);
        $display("timeout enable cycles=%0d", cnt);

        send_cmd(1'b0, 32'h0000_0040, 8'd3);
        read_beat(32'h0000_0040, 0, 32'h0000_0011, 1'b0);
        consume_rd();
        wait_enable();
        check("t6_enable", bus.mem_enable, 2'b01);
        bus.mem_ready[0] = 1'b1;
        bus.mem_read_data[0 +: DW] = 32'h0000_0022;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.mem_ready = '0;
        bus.abort = 1'b0;
        check("t6_code", error_code, 8'h06);
        check("t6_error", error, 1'b1);
        check("t6_beats", beat_count, 9'd1);
        check("t6_enable_drop", bus.mem_enable, 2'b00);
        check("t6_no_capture", bus.rd_data_valid, 1'b0);
        @(negedge clk);
        check("t6_idle", busy, 1'b0);
        send_cmd(1'b0, 32'h0000_0080, 8'd0);
        check("t6_error_cleared", error, 1'b0);
        check("t6_code_cleared", error_code, 8'h00);
        read_beat(32'h0000_0080, 0, 32'h1234_5678, 1'b0);
        check("t6_done", done, 1'b1);
        check("t6_after_beats", beat_count, 9'd1);
        check("t6_after_error", error, 1'b0);
        consume_rd();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
